// File: rtl/ntt_iter_core.sv
// Iterative radix-2 DIT forward/inverse NTT over Z_Q with one shared butterfly.
// Coefficients are loaded bit-reversed, transformed in place and returned in natural order.
module ntt_iter_core #(
    parameter int W         = 9,
    parameter int LOGD      = 3,
    parameter int Q         = 257,
    parameter int OMEGA     = 4,
    parameter int OMEGA_INV = 193,
    parameter int D_INV     = 225,
    localparam int D        = 2 ** LOGD
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_inverse,
    input  logic [D*W-1:0] in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D*W-1:0] out_data,
    output logic           busy
);

    localparam int SW = $clog2(LOGD + 1);
    localparam logic [W-1:0]   Q_W    = W'(Q);
    localparam logic [W:0]     Q_W1   = (W + 1)'(Q);
    localparam logic [2*W-1:0] Q_2W   = (2 * W)'(Q);
    localparam logic [2*W-1:0] DINV_2W = (2 * W)'(D_INV);

    // Powers w^0..w^(D-1) packed W bits apiece, evaluated at elaboration.
    function automatic logic [D*W-1:0] tw_table(input longint unsigned w);
        logic [D*W-1:0]  t;
        longint unsigned acc;
        t   = '0;
        acc = 1;
        for (int e = 0; e < D; e++) begin
            t[e*W +: W] = W'(acc);
            acc = (acc * w) % longint'(Q);
        end
        return t;
    endfunction

    localparam logic [D*W-1:0] TW_FWD = tw_table(longint'(OMEGA));
    localparam logic [D*W-1:0] TW_INV = tw_table(longint'(OMEGA_INV));

    function automatic logic [LOGD-1:0] bit_rev(input logic [LOGD-1:0] x);
        logic [LOGD-1:0] r;
        for (int b = 0; b < LOGD; b++) r[b] = x[LOGD-1-b];
        return r;
    endfunction

    function automatic logic [W-1:0] reduce_once(input logic [W-1:0] x);
        return (x >= Q_W) ? x - Q_W : x;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_SCALE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    coef_q [D];
    logic [W-1:0]    coef_d [D];
    logic [SW-1:0]   stage_q, stage_d;
    logic [LOGD-1:0] cnt_q, cnt_d;
    logic            inv_q, inv_d;

    logic [LOGD-1:0] h_val, h_mask, idx_a, idx_b, tw_exp;
    int              tw_sel;
    logic [W-1:0]    tw, bf_a, bf_b, bf_t, sc_in, sc_res;
    logic [2*W-1:0]  bf_prod, sc_prod;
    logic [W:0]      bf_sum, bf_diff;

    // Butterfly j of stage s touches (p, p+h) where p inserts a zero at bit s of j.
    always_comb begin
        h_val   = LOGD'(1) << stage_q;
        h_mask  = h_val - LOGD'(1);
        idx_a   = ((cnt_q & ~h_mask) << 1) | (cnt_q & h_mask);
        idx_b   = idx_a | h_val;
        tw_exp  = (cnt_q & h_mask) << (LOGD'(LOGD - 1) - LOGD'(stage_q));
        tw_sel  = int'(tw_exp) * W;
        tw      = inv_q ? TW_INV[tw_sel +: W] : TW_FWD[tw_sel +: W];
        bf_a    = coef_q[idx_a];
        bf_b    = coef_q[idx_b];
        bf_prod = {{W{1'b0}}, tw} * {{W{1'b0}}, bf_b};
        bf_t    = W'(bf_prod % Q_2W);
        bf_sum  = {1'b0, bf_a} + {1'b0, bf_t};
        if (bf_sum >= Q_W1) bf_sum = bf_sum - Q_W1;
        bf_diff = {1'b0, bf_a} - {1'b0, bf_t};
        if (bf_a < bf_t) bf_diff = bf_diff + Q_W1;
        sc_in   = coef_q[cnt_q];
        sc_prod = {{W{1'b0}}, sc_in} * DINV_2W;
        sc_res  = W'(sc_prod % Q_2W);
    end

    always_comb begin
        state_d = state_q;
        coef_d  = coef_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    inv_d = in_inverse;
                    for (int i = 0; i < D; i++)
                        coef_d[bit_rev(LOGD'(i))] = reduce_once(in_data[i*W +: W]);
                    stage_d = '0;
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                coef_d[idx_a] = W'(bf_sum);
                coef_d[idx_b] = W'(bf_diff);
                if (cnt_q == LOGD'(D / 2 - 1)) begin
                    cnt_d = '0;
                    if (stage_q == SW'(LOGD - 1)) begin
                        stage_d = '0;
                        state_d = inv_q ? S_SCALE : S_DONE;
                    end else begin
                        stage_d = stage_q + SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + LOGD'(1);
                end
            end
            S_SCALE: begin
                coef_d[cnt_q] = sc_res;
                if (cnt_q == LOGD'(D - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + LOGD'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            for (int i = 0; i < D; i++) coef_q[i] <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            coef_q  <= coef_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < D; i++) out_data[i*W +: W] = coef_q[i];
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule
